// File: rtl/i2c_bus_filter.sv
// I2C pad conditioning: synchronizes and deglitches SCL/SDA, flags edges and
// START/STOP conditions, and tracks bus occupancy including the bus-free time.
module i2c_bus_filter #(
  parameter int CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                scl_i,
  input  logic                sda_i,
  input  logic [3:0]          filt_cycles_i,
  input  logic [CntWidth-1:0] tbuf_i,
  output logic                scl_o,
  output logic                sda_o,
  output logic                scl_rise_o,
  output logic                scl_fall_o,
  output logic                start_o,
  output logic                stop_o,
  output logic                bus_busy_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    FREE_WAIT = 2'd2
  } state_e;

  localparam logic [CntWidth-1:0] TimerMax = '1;
  localparam logic [CntWidth-1:0] TimerOne = CntWidth'(1);

  // Bit 0 carries SCL, bit 1 carries SDA.
  logic [1:0] w_raw;
  logic [1:0] w_filt;
  logic [1:0] w_prev;

  assign w_raw = {sda_i, scl_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_line
    logic [1:0] r_sync;
    logic [3:0] r_cnt;
    logic       r_filt;
    logic       r_prev;

    // ">=" lets a lowered filter length take effect on a count already running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_sync <= 2'b11;
        r_cnt  <= '0;
        r_filt <= 1'b1;
        r_prev <= 1'b1;
      end else begin
        r_sync <= {r_sync[0], w_raw[gi]};
        r_prev <= r_filt;
        if (r_sync[1] == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt >= filt_cycles_i) begin
          r_filt <= r_sync[1];
          r_cnt  <= '0;
        end else if (r_cnt != 4'hF) begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end

    assign w_filt[gi] = r_filt;
    assign w_prev[gi] = r_prev;
  end

  logic w_scl_hold;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  // A simultaneous SCL/SDA change fails w_scl_hold, so it is never a START/STOP.
  assign w_scl_hold = w_filt[0] & w_prev[0];
  assign w_scl_rise = w_filt[0] & ~w_prev[0];
  assign w_scl_fall = ~w_filt[0] & w_prev[0];
  assign w_start    = w_scl_hold & w_prev[1] & ~w_filt[1];
  assign w_stop     = w_scl_hold & ~w_prev[1] & w_filt[1];

  logic r_scl_rise;
  logic r_scl_fall;
  logic r_start;
  logic r_stop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_rise <= w_scl_rise;
      r_scl_fall <= w_scl_fall;
      r_start    <= w_start;
      r_stop     <= w_stop;
    end
  end

  state_e              r_state;
  state_e              w_state_next;
  logic [CntWidth-1:0] r_timer;
  logic                w_busy;
  logic                r_bus_busy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_start || w_scl_fall) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_stop) w_state_next = FREE_WAIT;
      end
      FREE_WAIT: begin
        if (w_start || !w_filt[0] || !w_filt[1]) w_state_next = BUSY;
        else if (r_timer >= tbuf_i)              w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = (r_state != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_timer    <= '0;
      r_bus_busy <= 1'b0;
    end else begin
      r_bus_busy <= w_busy;
      if (r_state == BUSY && w_state_next == FREE_WAIT) begin
        r_timer <= '0;
      end else if (r_state == FREE_WAIT && r_timer != TimerMax) begin
        r_timer <= r_timer + TimerOne;
      end
    end
  end

  assign scl_o      = w_filt[0];
  assign sda_o      = w_filt[1];
  assign scl_rise_o = r_scl_rise;
  assign scl_fall_o = r_scl_fall;
  assign start_o    = r_start;
  assign stop_o     = r_stop;
  assign bus_busy_o = r_bus_busy;

endmodule

// File: tb/tb_i2c_bus_filter.sv
// Directed bench for i2c_bus_filter: glitch rejection, edge timing,
// START/STOP detection, bus-free timing and asynchronous reset.
module tb_i2c_bus_filter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        scl_i;
  logic        sda_i;
  logic [3:0]  filt_cycles_i;
  logic [15:0] tbuf_i;
  logic        scl_o;
  logic        sda_o;
  logic        scl_rise_o;
  logic        scl_fall_o;
  logic        start_o;
  logic        stop_o;
  logic        bus_busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rise, n_fall, n_start, n_stop;

  always #5 clk_i = ~clk_i;

  i2c_bus_filter #(.CntWidth(16)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .scl_i        (scl_i),
    .sda_i        (sda_i),
    .filt_cycles_i(filt_cycles_i),
    .tbuf_i       (tbuf_i),
    .scl_o        (scl_o),
    .sda_o        (sda_o),
    .scl_rise_o   (scl_rise_o),
    .scl_fall_o   (scl_fall_o),
    .start_o      (start_o),
    .stop_o       (stop_o),
    .bus_busy_o   (bus_busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0h", tag, got);
    end
  endtask

  // Inputs are changed just after this returns, so the next edge is sampling edge 1.
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (scl_rise_o) n_rise++;
    if (scl_fall_o) n_fall++;
    if (start_o)    n_start++;
    if (stop_o)     n_stop++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_counts();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
  endtask

  function automatic logic [6:0] outs();
    return {scl_o, sda_o, scl_rise_o, scl_fall_o, start_o, stop_o, bus_busy_o};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    logic ok;
    clr_counts();
    rst_ni = 1'b0; scl_i = 1'b1; sda_i = 1'b1;
    filt_cycles_i = 4'd3; tbuf_i = 16'd10;

    ticks(3);
    check_eq("reset_outs", outs(), 7'b1100000);
    rst_ni = 1'b1;
    ticks(5);
    check_eq("post_reset_outs", outs(), 7'b1100000);

    // 3-clock low glitch with filter 3 is rejected
    clr_counts();
    scl_i = 1'b0; ticks(3); scl_i = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (scl_o !== 1'b1) ok = 1'b0;
    end
    check_eq("glitch_scl_o_held", ok, 1);
    check_eq("glitch_no_fall", n_fall, 0);

    // Held low: scl_o falls on edge 6, scl_fall_o one cycle later
    clr_counts();
    scl_i = 1'b0;
    ticks(5);
    check_eq("hold_scl_edge5", scl_o, 1);
    tick();
    check_eq("hold_scl_edge6", scl_o, 0);
    check_eq("hold_fall_edge6", scl_fall_o, 0);
    tick();
    check_eq("hold_fall_edge7", scl_fall_o, 1);
    tick();
    check_eq("hold_fall_edge8", scl_fall_o, 0);
    check_eq("hold_fall_count", n_fall, 1);
    check_eq("busy_after_fall", bus_busy_o, 1);
    scl_i = 1'b1;
    ticks(6);
    check_eq("rise_scl_edge6", scl_o, 1);
    tick();
    check_eq("rise_pulse_edge7", scl_rise_o, 1);
    ticks(3);
    check_eq("rise_count", n_rise, 1);

    // START then STOP, filter 0, tbuf 0
    filt_cycles_i = 4'd0; tbuf_i = 16'd0;
    ticks(2);
    clr_counts();
    sda_i = 1'b0;
    ticks(3);
    check_eq("start_sda_o", sda_o, 0);
    check_eq("start_not_yet", start_o, 0);
    tick();
    check_eq("start_pulse", start_o, 1);
    tick();
    check_eq("start_pulse_end", start_o, 0);
    ticks(5);
    sda_i = 1'b1;
    ticks(4);
    check_eq("stop_pulse", stop_o, 1);
    check_eq("stop_busy_e0", bus_busy_o, 1);
    tick();
    check_eq("stop_busy_e1", bus_busy_o, 1);
    tick();
    check_eq("stop_busy_e2", bus_busy_o, 0);
    check_eq("start_count", n_start, 1);
    check_eq("stop_count", n_stop, 1);

    // Simultaneous SCL/SDA changes are not START/STOP
    clr_counts();
    scl_i = 1'b0; sda_i = 1'b0;
    ticks(8);
    check_eq("simul_fall_start", n_start, 0);
    check_eq("simul_fall_stop", n_stop, 0);
    check_eq("simul_fall_edges", n_fall, 1);
    check_eq("simul_fall_busy", bus_busy_o, 1);
    scl_i = 1'b1; sda_i = 1'b1;
    ticks(8);
    check_eq("simul_rise_stop", n_stop, 0);
    check_eq("simul_rise_edges", n_rise, 1);
    check_eq("simul_rise_busy", bus_busy_o, 1);

    // STOP then idle bus with tbuf 10: busy for 11 more cycles, then drops
    tbuf_i = 16'd10;
    sda_i = 1'b0; ticks(6);
    sda_i = 1'b1; ticks(4);
    check_eq("tbuf_stop_pulse", stop_o, 1);
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (bus_busy_o !== 1'b1) ok = 1'b0;
    end
    check_eq("tbuf_busy_held", ok, 1);
    tick();
    check_eq("tbuf_busy_drop", bus_busy_o, 0);

    // STOP, then START injected at timer=5: never returns to IDLE
    sda_i = 1'b0; ticks(6);
    sda_i = 1'b1; ticks(4);
    check_eq("restart_stop_pulse", stop_o, 1);
    ticks(5);
    clr_counts();
    sda_i = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus_busy_o !== 1'b1) ok = 1'b0;
    end
    check_eq("restart_busy_held", ok, 1);
    check_eq("restart_start_count", n_start, 1);

    // Asynchronous reset mid-transaction with SCL low
    scl_i = 1'b0;
    ticks(6);
    check_eq("pre_reset_scl_o", scl_o, 0);
    check_eq("pre_reset_busy", bus_busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("async_reset_outs", outs(), 7'b1100000);
    scl_i = 1'b1; sda_i = 1'b1;
    ticks(2);
    rst_ni = 1'b1;
    clr_counts();
    ticks(10);
    check_eq("release_no_pulses", n_rise + n_fall + n_start + n_stop, 0);
    check_eq("release_outs", outs(), 7'b1100000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
